fifo_param: RTL and testbench

Parametrised synchronous FIFO that succeeds the fixed 8-entry FIFO. Depth and width are generic. It uses an explicit occupancy counter with one extra bit instead of pointer-difference flags. Almost-full and almost-empty thresholds are programmable at run time, and a registered read port carries a valid strobe. It sits between the packet-staging logic and downstream consumers wherever a buffered, flow-controlled byte stream is needed.

---
 rtl/fifo_param_if.sv | 39 +++
 rtl/fifo_param.sv | 99 +++++++++
 tb/tb_fifo_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// fifo_param_if: bundles the data, request, threshold and status signals of
// fifo_param into one interface.
//   master modport: the producer/consumer side (drives data, requests and
//                   thresholds; observes read data, valid, flags, errors, count)
//   slave modport : the FIFO side (the mirror image)
// Parameters must match the ones given to the fifo_param instance.
interface fifo_param_if #(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8
);
  localparam int CNTW = $clog2(LENGTH) + 1;

  logic [BITNUMBER-1:0] Fifo_Data_in;
  logic                 Fifo_wr;
  logic                 Fifo_rd;
  logic [CNTW-1:0]      umbral_alto;
  logic [CNTW-1:0]      umbral_bajo;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 Fifo_valid;
  logic                 Fifo_full;
  logic                 Fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 Fifo_wr_error;
  logic                 Fifo_rd_error;
  logic [CNTW-1:0]      Fifo_count;

  modport master (
    output Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo,
    input  Fifo_Data_out, Fifo_valid, Fifo_full, Fifo_empty,
           almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_count
  );

  modport slave (
    input  Fifo_Data_in, Fifo_wr, Fifo_rd, umbral_alto, umbral_bajo,
    output Fifo_Data_out, Fifo_valid, Fifo_full, Fifo_empty,
           almost_full, almost_empty, Fifo_wr_error, Fifo_rd_error, Fifo_count
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO, LENGTH words of BITNUMBER bits.
// An explicit occupancy counter (one bit wider than the pointers) drives every
// flag; almost-full/almost-empty thresholds come in at run time and act
// combinationally. The read port is registered and strobes Fifo_valid for one
// cycle per popped word. Rejected requests raise a one-cycle error strobe and
// change nothing else.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high; clears pointers, count, read port, errors
//   bus   - fifo_param_if.slave (data in/out, wr/rd requests, thresholds,
//           valid, full/empty/almost flags, error strobes, occupancy count)
// LENGTH must be a power of two and at least 4.
module fifo_param #(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);
  localparam int PTRW = $clog2(LENGTH);
  localparam int CNTW = PTRW + 1;

  logic [BITNUMBER-1:0] mem [LENGTH];
  logic [PTRW-1:0]      wr_ptr;
  logic [PTRW-1:0]      rd_ptr;
  logic [CNTW-1:0]      count;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid;
  logic                 wr_error;
  logic                 rd_error;

  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic wr_ok;
  logic rd_ok;

  // Flags and request acceptance, all derived from the occupancy counter
  always_comb begin
    empty        = (count == {CNTW{1'b0}});
    full         = (count == CNTW'(LENGTH));
    // count never exceeds LENGTH, so a low threshold of LENGTH or more
    // naturally pins almost_empty high, and a high threshold of 0 pins
    // almost_full high.
    almost_full  = (count >= bus.umbral_alto);
    almost_empty = (count <= bus.umbral_bajo);
    rd_ok        = bus.Fifo_rd && !empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_ok        = bus.Fifo_wr && (!full || rd_ok);
  end

  // Storage array; not cleared by reset, and a reset cycle stores nothing
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr] <= bus.Fifo_Data_in;
    end
  end

  // Pointers, occupancy, registered read port and error strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= {PTRW{1'b0}};
      rd_ptr   <= {PTRW{1'b0}};
      count    <= {CNTW{1'b0}};
      data_out <= {BITNUMBER{1'b0}};
      valid    <= 1'b0;
      wr_error <= 1'b0;
      rd_error <= 1'b0;
    end else begin
      valid    <= rd_ok;
      wr_error <= bus.Fifo_wr && !wr_ok;
      rd_error <= bus.Fifo_rd && !rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + PTRW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.Fifo_Data_out = data_out;
  assign bus.Fifo_valid    = valid;
  assign bus.Fifo_full     = full;
  assign bus.Fifo_empty    = empty;
  assign bus.almost_full   = almost_full;
  assign bus.almost_empty  = almost_empty;
  assign bus.Fifo_wr_error = wr_error;
  assign bus.Fifo_rd_error = rd_error;
  assign bus.Fifo_count    = count;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed bench for fifo_param. Instance a is 8x8, instance b
// is 16x16; both share clock and reset. Inputs change 1 ns after the rising
// edge, outputs are checked at the same point.
module tb_fifo_param;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fifo_param_if #(.BITNUMBER(8),  .LENGTH(8))  bus_a ();
  fifo_param_if #(.BITNUMBER(16), .LENGTH(16)) bus_b ();

  fifo_param #(.BITNUMBER(8),  .LENGTH(8))  dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fifo_param #(.BITNUMBER(16), .LENGTH(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic wr, input logic rd, input logic [7:0] d);
    bus_a.Fifo_wr      = wr;
    bus_a.Fifo_rd      = rd;
    bus_a.Fifo_Data_in = d;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int exp_cnt;
    int op;
    n_checks = 0;
    n_fail   = 0;

    reset = 1'b1;
    set_a(1'b1, 1'b0, 8'hAA);
    bus_a.umbral_alto = 4'd6;
    bus_a.umbral_bajo = 4'd1;
    bus_b.Fifo_wr = 1'b0;
    bus_b.Fifo_rd = 1'b0;
    bus_b.Fifo_Data_in = 16'h0000;
    bus_b.umbral_alto = 5'd12;
    bus_b.umbral_bajo = 5'd4;

    // Reset with a pending write
    cyc();
    chk("rst_count", bus_a.Fifo_count, 0);
    chk("rst_empty", bus_a.Fifo_empty, 1);
    chk("rst_full", bus_a.Fifo_full, 0);
    chk("rst_valid", bus_a.Fifo_valid, 0);
    chk("rst_wr_err", bus_a.Fifo_wr_error, 0);
    chk("rst_rd_err", bus_a.Fifo_rd_error, 0);
    chk("rst_dout", bus_a.Fifo_Data_out, 0);
    chk("rst_aempty", bus_a.almost_empty, 1);

    // Read right after reset: nothing was stored
    reset = 1'b0;
    set_a(1'b0, 1'b1, 8'h00);
    cyc();
    chk("post_rst_rd_err", bus_a.Fifo_rd_error, 1);
    chk("post_rst_count", bus_a.Fifo_count, 0);
    chk("post_rst_valid", bus_a.Fifo_valid, 0);
    set_a(1'b0, 1'b0, 8'h00);
    cyc();
    chk("rd_err_clear", bus_a.Fifo_rd_error, 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      set_a(1'b1, 1'b0, 8'(i));
      cyc();
      chk("fill_count", bus_a.Fifo_count, i);
      chk("fill_afull", bus_a.almost_full, (i >= 6) ? 1 : 0);
      chk("fill_aempty", bus_a.almost_empty, (i <= 1) ? 1 : 0);
      chk("fill_full", bus_a.Fifo_full, (i == 8) ? 1 : 0);
      chk("fill_wr_err", bus_a.Fifo_wr_error, 0);
    end

    // Overflow
    set_a(1'b1, 1'b0, 8'h09);
    cyc();
    chk("ovf_wr_err", bus_a.Fifo_wr_error, 1);
    chk("ovf_count", bus_a.Fifo_count, 8);
    chk("ovf_full", bus_a.Fifo_full, 1);
    set_a(1'b0, 1'b0, 8'h00);
    cyc();
    chk("ovf_err_clear", bus_a.Fifo_wr_error, 0);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      set_a(1'b0, 1'b1, 8'h00);
      cyc();
      chk("drain_data", bus_a.Fifo_Data_out, i);
      chk("drain_valid", bus_a.Fifo_valid, 1);
      chk("drain_count", bus_a.Fifo_count, 8 - i);
      chk("drain_aempty", bus_a.almost_empty, ((8 - i) <= 1) ? 1 : 0);
      chk("drain_empty", bus_a.Fifo_empty, (i == 8) ? 1 : 0);
    end
    set_a(1'b0, 1'b0, 8'h00);
    cyc();
    chk("idle_valid", bus_a.Fifo_valid, 0);
    chk("idle_hold", bus_a.Fifo_Data_out, 8'h08);

    // Underflow
    set_a(1'b0, 1'b1, 8'h00);
    cyc();
    chk("udf_rd_err", bus_a.Fifo_rd_error, 1);
    chk("udf_valid", bus_a.Fifo_valid, 0);
    chk("udf_hold", bus_a.Fifo_Data_out, 8'h08);
    set_a(1'b0, 1'b0, 8'h00);
    cyc();
    chk("udf_err_clear", bus_a.Fifo_rd_error, 0);

    // Simultaneous read+write at full
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b0, 8'(8'h11 + i));
      cyc();
    end
    chk("refill_full", bus_a.Fifo_full, 1);
    set_a(1'b1, 1'b1, 8'h19);
    cyc();
    chk("rw_full_data", bus_a.Fifo_Data_out, 8'h11);
    chk("rw_full_valid", bus_a.Fifo_valid, 1);
    chk("rw_full_count", bus_a.Fifo_count, 8);
    chk("rw_full_wr_err", bus_a.Fifo_wr_error, 0);
    chk("rw_full_rd_err", bus_a.Fifo_rd_error, 0);
    for (int i = 0; i < 8; i++) begin
      set_a(1'b0, 1'b1, 8'h00);
      cyc();
      chk("rw_drain_data", bus_a.Fifo_Data_out, 8'h12 + i);
    end
    chk("rw_drain_empty", bus_a.Fifo_empty, 1);

    // Simultaneous read+write at empty
    set_a(1'b1, 1'b1, 8'h20);
    cyc();
    chk("rw_empty_count", bus_a.Fifo_count, 1);
    chk("rw_empty_rd_err", bus_a.Fifo_rd_error, 1);
    chk("rw_empty_wr_err", bus_a.Fifo_wr_error, 0);
    chk("rw_empty_valid", bus_a.Fifo_valid, 0);
    chk("rw_empty_hold", bus_a.Fifo_Data_out, 8'h19);
    set_a(1'b0, 1'b1, 8'h00);
    cyc();
    chk("rw_empty_data", bus_a.Fifo_Data_out, 8'h20);
    chk("rw_empty_cnt0", bus_a.Fifo_count, 0);

    // Wrap-around streaming, occupancy oscillates 3..5
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, 8'(8'h30 + i));
      q.push_back(8'(8'h30 + i));
      cyc();
    end
    exp_cnt = 4;
    for (int k = 0; k < 20; k++) begin
      op = k % 5;
      set_a((op == 0 || op == 1 || op == 4) ? 1'b1 : 1'b0,
            (op == 0 || op == 2 || op == 3) ? 1'b1 : 1'b0,
            8'(8'h40 + k));
      exp_d = 8'h00;
      if (bus_a.Fifo_rd) begin
        exp_d = q.pop_front();
        exp_cnt--;
      end
      if (bus_a.Fifo_wr) begin
        q.push_back(8'(8'h40 + k));
        exp_cnt++;
      end
      cyc();
      chk("wrap_count", bus_a.Fifo_count, exp_cnt);
      chk("wrap_valid", bus_a.Fifo_valid, (op == 0 || op == 2 || op == 3) ? 1 : 0);
      if (op == 0 || op == 2 || op == 3) begin
        chk("wrap_data", bus_a.Fifo_Data_out, exp_d);
      end
    end

    // Threshold changes act without a clock edge (count is 4 here)
    set_a(1'b0, 1'b0, 8'h00);
    cyc();
    bus_a.umbral_bajo = 4'd8;
    #1;
    chk("thr_bajo8", bus_a.almost_empty, 1);
    bus_a.umbral_bajo = 4'd3;
    #1;
    chk("thr_bajo3", bus_a.almost_empty, 0);
    bus_a.umbral_alto = 4'd4;
    #1;
    chk("thr_alto4", bus_a.almost_full, 1);
    bus_a.umbral_alto = 4'd5;
    #1;
    chk("thr_alto5", bus_a.almost_full, 0);

    // Reset mid-stream with a concurrent write
    reset = 1'b1;
    set_a(1'b1, 1'b0, 8'h77);
    cyc();
    chk("mid_rst_count", bus_a.Fifo_count, 0);
    chk("mid_rst_empty", bus_a.Fifo_empty, 1);
    chk("mid_rst_valid", bus_a.Fifo_valid, 0);
    reset = 1'b0;
    bus_a.umbral_alto = 4'd0;
    set_a(1'b0, 1'b1, 8'h00);
    #1;
    chk("thr_alto0", bus_a.almost_full, 1);
    cyc();
    chk("mid_rst_rd_err", bus_a.Fifo_rd_error, 1);
    set_a(1'b0, 1'b0, 8'h00);

    // 16x16 instance
    for (int i = 1; i <= 16; i++) begin
      bus_b.Fifo_wr = 1'b1;
      bus_b.Fifo_Data_in = (i == 1) ? 16'hBEEF : 16'(16'h1000 + i);
      cyc();
      chk("b_count", bus_b.Fifo_count, i);
      chk("b_afull", bus_b.almost_full, (i >= 12) ? 1 : 0);
      chk("b_aempty", bus_b.almost_empty, (i <= 4) ? 1 : 0);
      chk("b_full", bus_b.Fifo_full, (i == 16) ? 1 : 0);
    end
    bus_b.Fifo_Data_in = 16'h5555;
    cyc();
    chk("b_ovf_err", bus_b.Fifo_wr_error, 1);
    chk("b_ovf_count", bus_b.Fifo_count, 16);
    bus_b.Fifo_wr = 1'b0;
    bus_b.Fifo_rd = 1'b1;
    cyc();
    chk("b_data", bus_b.Fifo_Data_out, 16'hBEEF);
    chk("b_valid", bus_b.Fifo_valid, 1);
    chk("b_count15", bus_b.Fifo_count, 15);
    bus_b.Fifo_rd = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
